icache_responder: RTL and testbench

- Direct-mapped, read-only instruction cache.
- Serves the instruction fetcher's request/response handshake and fetches missing words from the memory controller.
- Sits between the fetcher and the memory controller; one word per line, one outstanding request at a time.

---
 rtl/icache_responder.sv | 147 ++++++++++++++
 tb/tb_icache_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache: one 32-bit word per line, one
// outstanding fetch at a time, misses filled from the memory controller.
module icache_responder #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        instr_valid,
  output logic [31:0] instr_2if,
  input  logic        rollback_signal,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_data,
  output logic [1:0]  dbg_state
);
  // Handshakes: a request is accepted on any rdy cycle in IDLE with if_req high
  // and no rollback; instr_valid is a one-cycle pulse with no back-pressure;
  // mem_req_valid is a level held with a stable address until the single-cycle
  // mem_data_valid pulse that completes it.

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_data [LINES];
  logic [29:0]           r_req_pc;
  logic [29:0]           w_req_pc_nxt;
  logic                  r_instr_valid;
  logic                  w_instr_valid_nxt;
  logic [31:0]           r_instr_2if;
  logic [31:0]           w_instr_2if_nxt;
  logic                  r_mem_req_valid;
  logic                  w_mem_req_valid_nxt;
  logic [31:0]           r_mem_req_addr;
  logic [31:0]           w_mem_req_addr_nxt;
  logic                  r_abort;
  logic                  w_abort_nxt;
  logic                  w_fill;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_BITS-1:0]   w_fill_tag;

  assign w_idx      = if_pc[INDEX_BITS+1:2];
  assign w_tag      = if_pc[31:INDEX_BITS+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // r_req_pc holds the word address, so index and tag sit two bits lower.
  assign w_fill_idx = r_req_pc[INDEX_BITS-1:0];
  assign w_fill_tag = r_req_pc[29:INDEX_BITS];

  always_comb begin
    w_state_nxt         = r_state;
    w_req_pc_nxt        = r_req_pc;
    w_instr_valid_nxt   = 1'b0;
    w_instr_2if_nxt     = r_instr_2if;
    w_mem_req_valid_nxt = r_mem_req_valid;
    w_mem_req_addr_nxt  = r_mem_req_addr;
    w_abort_nxt         = r_abort;
    w_fill              = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req && !rollback_signal) begin
          w_req_pc_nxt = if_pc[31:2];
          if (w_hit) begin
            w_instr_valid_nxt = 1'b1;
            w_instr_2if_nxt   = r_data[w_idx];
            w_state_nxt       = S_DONE;
          end else begin
            w_mem_req_valid_nxt = 1'b1;
            w_mem_req_addr_nxt  = if_pc & 32'hFFFF_FFFC;
            w_state_nxt         = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (mem_data_valid) begin
          w_fill              = 1'b1;
          w_mem_req_valid_nxt = 1'b0;
          // The line is filled even when the response itself is discarded.
          if (r_abort || rollback_signal) begin
            w_abort_nxt = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_instr_valid_nxt = 1'b1;
            w_instr_2if_nxt   = mem_data;
            w_state_nxt       = S_DONE;
          end
        end else if (rollback_signal) begin
          w_abort_nxt = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_valid         <= '0;
      r_req_pc        <= '0;
      r_instr_valid   <= 1'b0;
      r_instr_2if     <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_abort         <= 1'b0;
    end else if (rdy) begin
      r_state         <= w_state_nxt;
      r_req_pc        <= w_req_pc_nxt;
      r_instr_valid   <= w_instr_valid_nxt;
      r_instr_2if     <= w_instr_2if_nxt;
      r_mem_req_valid <= w_mem_req_valid_nxt;
      r_mem_req_addr  <= w_mem_req_addr_nxt;
      r_abort         <= w_abort_nxt;
      if (w_fill) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_data;
    end
  end

  assign instr_valid   = r_instr_valid;
  assign instr_2if     = r_instr_2if;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: sequenced fetches against a memory model, with
// a scoreboard queue of expected instruction words popped on each pulse.
module tb_icache_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_2if;
  logic        rollback_signal = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_data_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  bit          m_valid [256];
  logic [21:0] m_tag   [256];

  icache_responder #(.INDEX_BITS(8), .TAG_BITS(22)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_req(if_req), .if_pc(if_pc),
    .instr_valid(instr_valid), .instr_2if(instr_2if),
    .rollback_signal(rollback_signal), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_data_valid(mem_data_valid),
    .mem_data(mem_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h4) return 32'h0040_0093;
    return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endfunction

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rdy && instr_valid) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
      else chk("resp_data", instr_2if, exp_q.pop_front());
    end
  end

  // rb_at: miss-wait cycle to pulse rollback (== lat means with the data),
  // stall_at: miss-wait cycle to drop rdy for 4 cycles, hold: keep if_req high.
  task automatic fetch(input logic [31:0] pc, input int lat, input int rb_at,
                       input int stall_at, input bit hold);
    logic [7:0]  idx;
    logic [31:0] w;
    bit          hit;
    bit          aborted;
    idx = pc[9:2];
    hit = m_valid[idx] && (m_tag[idx] == pc[31:10]);
    w   = mem_word(pc & 32'hFFFF_FFFC);
    if_req = 1'b1;
    if_pc  = pc;
    if (hit) begin
      exp_q.push_back(w);
      cycle();
      chk("hit_valid", instr_valid, 1);
      chk("hit_no_mem", mem_req_valid, 0);
      if (!hold) if_req = 1'b0;
      cycle();
      chk("hit_pulse_width", instr_valid, 0);
    end else begin
      cycle();
      chk("miss_req", mem_req_valid, 1);
      chk("miss_addr", mem_req_addr, pc & 32'hFFFF_FFFC);
      chk("miss_no_pulse", instr_valid, 0);
      if (!hold) if_req = 1'b0;
      for (int i = 0; i < lat; i++) begin
        if (i == rb_at) rollback_signal = 1'b1;
        if (i == stall_at) begin
          rdy = 1'b0;
          repeat (4) begin
            cycle();
            chk("stall_req", mem_req_valid, 1);
            chk("stall_addr", mem_req_addr, pc & 32'hFFFF_FFFC);
            chk("stall_state", dbg_state, 1);
          end
          rdy = 1'b1;
        end
        cycle();
        rollback_signal = 1'b0;
        chk("miss_hold_req", mem_req_valid, 1);
        chk("miss_hold_addr", mem_req_addr, pc & 32'hFFFF_FFFC);
      end
      aborted = (rb_at >= 0) && (rb_at <= lat);
      if (rb_at == lat) rollback_signal = 1'b1;
      mem_data_valid = 1'b1;
      mem_data = w;
      if (!aborted) exp_q.push_back(w);
      cycle();
      mem_data_valid = 1'b0;
      rollback_signal = 1'b0;
      mem_data = $urandom();
      m_valid[idx] = 1'b1;
      m_tag[idx] = pc[31:10];
      chk("fill_drop_req", mem_req_valid, 0);
      chk("fill_pulse", instr_valid, {31'd0, !aborted});
      cycle();
      chk("after_fill", instr_valid, 0);
      chk("after_fill_state", dbg_state, 0);
    end
  endtask

  initial begin
    logic [31:0] pc;
    int          lat;
    int          rb;
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_2if", instr_2if, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_state", dbg_state, 0);

    // cold miss with if_req held through DONE, then a hit on the same pc
    fetch(32'h4, 5, -1, -1, 1'b1);
    fetch(32'h4, 0, -1, -1, 1'b0);
    // conflict at index 1
    fetch(32'h404, 3, -1, -1, 1'b0);
    fetch(32'h4, 2, -1, -1, 1'b0);
    // rollback during miss, then hit
    fetch(32'h40, 5, 2, -1, 1'b0);
    fetch(32'h40, 0, -1, -1, 1'b0);
    // rollback together with mem_data_valid
    fetch(32'h44, 3, 3, -1, 1'b0);
    fetch(32'h44, 0, -1, -1, 1'b0);
    // stale-pc guard
    fetch(32'h8, 3, -1, -1, 1'b1);
    fetch(32'hC, 3, -1, -1, 1'b0);
    // stall mid-miss
    fetch(32'h20, 6, -1, 2, 1'b0);
    fetch(32'h20, 0, -1, -1, 1'b0);

    // rollback in IDLE blocks acceptance of a would-be hit
    if_req = 1'b1;
    if_pc = 32'h4;
    rollback_signal = 1'b1;
    cycle();
    chk("idle_rb_no_pulse", instr_valid, 0);
    chk("idle_rb_no_req", mem_req_valid, 0);
    chk("idle_rb_state", dbg_state, 0);
    rollback_signal = 1'b0;
    if_req = 1'b0;
    cycle();

    // reset mid-miss, stray data afterwards, cache invalidated
    if_req = 1'b1;
    if_pc = 32'h100;
    cycle();
    chk("pre_rst_req", mem_req_valid, 1);
    if_req = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_reset();
    chk("midrst_req", mem_req_valid, 0);
    chk("midrst_state", dbg_state, 0);
    mem_data_valid = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    cycle();
    mem_data_valid = 1'b0;
    chk("stray_no_pulse", instr_valid, 0);
    chk("stray_state", dbg_state, 0);
    fetch(32'h100, 2, -1, -1, 1'b0);
    fetch(32'h4, 2, -1, -1, 1'b0);

    // random traffic over a few conflicting tags
    for (int n = 0; n < 24; n++) begin
      pc  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
      lat = $urandom_range(1, 6);
      rb  = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, lat)) : -1;
      fetch(pc, lat, rb, -1, 1'b0);
    end

    repeat (2) cycle();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
